data_mem_ctrl: RTL and testbench

Byte-addressable data memory for the processor's load/store path: a synchronous word RAM behind a valid/ready request port and a one-cycle response pulse. It supports byte, halfword, word and (Width=64) doubleword accesses, with byte-lane write merging and sign/zero extension on reads. Wait states are configurable, and alignment and range errors are detected. It replaces the bare single-port word RAM on the data side and keeps that RAM's parametrised width and depth.

---
 rtl/data_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data RAM behind a valid/ready request port, with byte-lane store merging and load extension.
// Latency: response pulse WaitStates+1 cycles after the accepting edge; one request per WaitStates+2 cycles.
// Backpressure: reqReady is low from acceptance through the response cycle; responses cannot be stalled.
module data_mem_ctrl #(
    parameter int Width      = 32,
    parameter int Depth      = 32,
    parameter int AddrWidth  = 32,
    parameter int WaitStates = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWrite,
    input  logic [AddrWidth-1:0] reqAddr,
    input  logic [1:0]           reqSize,
    input  logic                 reqUnsigned,
    input  logic [Width-1:0]     reqWriteData,
    output logic                 rspValid,
    output logic [Width-1:0]     rspData,
    output logic                 rspError
);

    localparam int NB       = Width / 8;
    localparam int LaneBits = $clog2(NB);
    localparam int IdxW     = (Depth > 1) ? $clog2(Depth) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [Width-1:0] mem [Depth];

    state_t           state_q;
    logic [2:0]       cnt_q;
    logic             rdy_q;
    logic             vld_q;
    logic [Width-1:0] data_q;
    logic             err_q;
    logic [Width-1:0] pend_data_q;
    logic             pend_err_q;

    logic                 accept;
    logic [AddrWidth-1:0] word_idx;
    logic [LaneBits-1:0]  lane;
    logic [IdxW-1:0]      idx;
    logic [Width-1:0]     rd_word;
    logic [Width-1:0]     shifted;
    logic [Width-1:0]     ld_val;
    logic [Width-1:0]     rsp_d;
    logic [Width-1:0]     wr_data;
    logic [NB-1:0]        be;
    logic                 err_d;
    logic                 sign_bit;
    int                   nbytes;

    // The ready flop is forced low externally while reset is held.
    assign reqReady = rdy_q & ~reset;
    assign rspValid = vld_q;
    assign rspData  = data_q;
    assign rspError = err_q;
    assign accept   = reqValid & reqReady;

    assign word_idx = reqAddr >> LaneBits;
    assign lane     = reqAddr[LaneBits-1:0];
    assign idx      = word_idx[IdxW-1:0];
    assign rd_word  = mem[idx];
    assign shifted  = rd_word >> {lane, 3'b000};
    assign wr_data  = reqWriteData << {lane, 3'b000};

    // Decode the request: error checks, lane enables and the extended load value.
    always_comb begin
        nbytes   = 1 << reqSize;
        err_d    = ((int'(reqAddr[2:0]) & (nbytes - 1)) != 0)
                 || (nbytes > NB)
                 || (word_idx >= AddrWidth'(Depth));
        sign_bit = 1'b0;
        if (nbytes <= NB) begin
            sign_bit = ~reqUnsigned & shifted[nbytes*8-1];
        end
        ld_val = '0;
        for (int i = 0; i < Width; i++) begin
            ld_val[i] = (i < nbytes * 8) ? shifted[i] : sign_bit;
        end
        be = '0;
        for (int b = 0; b < NB; b++) begin
            be[b] = (b >= int'(lane)) && (b < int'(lane) + nbytes);
        end
        rsp_d = (err_d || reqWrite) ? '0 : ld_val;
    end

    // Store commits at the accepting edge; only enabled lanes of the addressed word change.
    always_ff @(posedge clk) begin
        if (accept && reqWrite && !err_d) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Request/wait/response sequencer with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rdy_q       <= 1'b1;
            vld_q       <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            pend_data_q <= '0;
            pend_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    vld_q <= 1'b0;
                    if (accept) begin
                        rdy_q       <= 1'b0;
                        pend_data_q <= rsp_d;
                        pend_err_q  <= err_d;
                        if (WaitStates == 0) begin
                            state_q <= RESP;
                            vld_q   <= 1'b1;
                            data_q  <= rsp_d;
                            err_q   <= err_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 3'((WaitStates > 0) ? WaitStates - 1 : 0);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= RESP;
                        vld_q   <= 1'b1;
                        data_q  <= pend_data_q;
                        err_q   <= pend_err_q;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized and directed bench for data_mem_ctrl against a byte-array reference model.
// Two builds: WaitStates=2 (main) and WaitStates=0 (latency/throughput only).
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid, reqReady, reqWrite, reqUnsigned;
    logic [31:0] reqAddr, reqWriteData, rspData;
    logic [1:0]  reqSize;
    logic        rspValid, rspError;

    logic        r0_valid, r0_ready, r0_write, r0_uns;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic [1:0]  r0_size;
    logic        r0_rvalid, r0_rerr;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] mm [64];

    always #5 clk = ~clk;

    data_mem_ctrl #(.Width(32), .Depth(16), .AddrWidth(32), .WaitStates(2)) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqAddr(reqAddr), .reqSize(reqSize), .reqUnsigned(reqUnsigned),
        .reqWriteData(reqWriteData),
        .rspValid(rspValid), .rspData(rspData), .rspError(rspError)
    );

    data_mem_ctrl #(.Width(32), .Depth(16), .AddrWidth(32), .WaitStates(0)) dut0 (
        .clk(clk), .reset(reset),
        .reqValid(r0_valid), .reqReady(r0_ready), .reqWrite(r0_write),
        .reqAddr(r0_addr), .reqSize(r0_size), .reqUnsigned(r0_uns),
        .reqWriteData(r0_wdata),
        .rspValid(r0_rvalid), .rspData(r0_rdata), .rspError(r0_rerr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Expected response from the byte-array model (store effects are applied separately).
    function automatic void model_rsp(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                                      input logic uns, output logic [31:0] ed, output logic ee);
        int nb;
        logic [31:0] v;
        nb = 1 << sz;
        ee = ((addr % nb) != 0) || ((addr / 4) >= 16) || (nb > 4);
        ed = 32'h0;
        if (!ee && !wr) begin
            v = 32'h0;
            for (int k = 0; k < nb; k++) v |= 32'(mm[addr + k]) << (8 * k);
            if (!uns && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
            ed = v;
        end
    endfunction

    function automatic void model_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
        for (int k = 0; k < (1 << sz); k++) mm[addr + k] = wd[8*k +: 8];
    endfunction

    // One complete transaction on the WaitStates=2 build; called and returns on a falling edge.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd,
                          output logic [31:0] od, output logic oe);
        logic [31:0] ed;
        logic ee;
        int n;
        model_rsp(wr, addr, sz, uns, ed, ee);
        n = 0;
        while (!reqReady && n < 50) begin @(negedge clk); n++; end
        check("ready_wait", reqReady, 1);
        reqValid = 1; reqWrite = wr; reqAddr = addr; reqSize = sz;
        reqUnsigned = uns; reqWriteData = wd;
        @(posedge clk);
        @(negedge clk);
        reqValid = 0; reqAddr = $urandom; reqWriteData = $urandom; reqWrite = 1;
        check("busy_ready", reqReady, 0);
        n = 1;
        while (!rspValid && n < 20) begin @(negedge clk); n++; end
        check("latency", n, 3);
        check("rsp_data", rspData, ed);
        check("rsp_err", rspError, ee);
        od = rspData; oe = rspError;
        @(negedge clk);
        check("pulse_len", rspValid, 0);
        if (wr && !ee) model_store(addr, sz, wd);
    endtask

    initial begin
        logic [31:0] d, ed, a;
        logic e, ee;
        int accs[$];
        int acc0[$];
        int last0;

        reset = 1; reqValid = 0; reqWrite = 0; reqAddr = 0; reqSize = 0;
        reqUnsigned = 0; reqWriteData = 0;
        r0_valid = 0; r0_write = 0; r0_addr = 0; r0_size = 2; r0_uns = 0; r0_wdata = 0;
        repeat (3) @(negedge clk);
        check("ready_in_reset", reqReady, 0);
        reset = 0;
        @(negedge clk);
        check("rst_ready", reqReady, 1);
        check("rst_rvalid", rspValid, 0);
        check("rst_rdata", rspData, 0);
        check("rst_rerr", rspError, 0);
        check("rst_ready_ws0", r0_ready, 1);

        // Give every word a defined value.
        for (int w = 0; w < 16; w++) do_req(1, w * 4, 2, 0, $urandom, d, e);

        // Directed store/load and lane merging.
        do_req(1, 32'h8, 2, 0, 32'hDEADBEEF, d, e);
        check("st_word_data", d, 0);
        check("st_word_err", e, 0);
        do_req(0, 32'h8, 2, 0, 0, d, e);
        check("ld_word", d, 32'hDEADBEEF);
        do_req(1, 32'h9, 0, 0, 32'h0000007F, d, e);
        do_req(0, 32'h8, 2, 0, 0, d, e);
        check("ld_merged", d, 32'hDEAD7FEF);
        do_req(0, 32'hB, 0, 0, 0, d, e);
        check("ld_sbyte", d, 32'hFFFFFFDE);
        do_req(0, 32'hA, 1, 1, 0, d, e);
        check("ld_uhalf", d, 32'h0000DEAD);

        // Error cases.
        do_req(0, 32'h3, 1, 0, 0, d, e);
        check("mis_err", e, 1); check("mis_data", d, 0);
        do_req(1, 32'h40, 2, 0, 32'hCAFEF00D, d, e);
        check("oor_st_err", e, 1);
        do_req(0, 32'h0, 3, 0, 0, d, e);
        check("size3_err", e, 1); check("size3_data", d, 0);
        do_req(0, 32'h40, 2, 0, 0, d, e);
        check("oor_ld_err", e, 1); check("oor_ld_data", d, 0);
        do_req(0, 32'h8, 2, 0, 0, d, e);
        check("after_err", d, 32'hDEAD7FEF);

        // reqValid held high; garbage stores driven whenever the port is busy.
        for (int i = 0; i < 20; i++) begin
            if (rspValid) begin
                model_rsp(0, 32'h8, 2, 0, ed, ee);
                check("hold_data", rspData, ed);
                check("hold_err", rspError, 0);
            end
            if (i < 16) begin
                reqValid = 1;
                if (reqReady) begin
                    accs.push_back(i);
                    reqWrite = 0; reqAddr = 32'h8; reqSize = 2; reqUnsigned = 0;
                end else begin
                    reqWrite = 1; reqAddr = $urandom_range(0, 63) & ~32'h3; reqSize = 2;
                    reqWriteData = $urandom;
                end
            end else begin
                reqValid = 0;
            end
            @(negedge clk);
        end
        check("hold_nacc", accs.size(), 4);
        for (int k = 1; k < accs.size(); k++) check("hold_gap", accs[k] - accs[k-1], 4);

        // Reset during the wait after a store: response dropped, store kept.
        reqValid = 1; reqWrite = 1; reqAddr = 32'h4; reqSize = 2; reqWriteData = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        reqValid = 0; reset = 1;
        model_store(32'h4, 2, 32'h12345678);
        @(negedge clk);
        check("mrst_rvalid", rspValid, 0);
        check("mrst_rdata", rspData, 0);
        check("mrst_rerr", rspError, 0);
        check("mrst_ready", reqReady, 0);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mrst_nopulse", rspValid, 0);
        end
        check("mrst_ready_back", reqReady, 1);
        do_req(0, 32'h4, 2, 0, 0, d, e);
        check("mrst_kept", d, 32'h12345678);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 71);
            do_req($urandom_range(0, 1), a, 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                   $urandom, d, e);
        end

        // WaitStates=0 build: store then back-to-back loads with reqValid held high.
        last0 = -10;
        for (int i = 0; i < 10; i++) begin
            if (r0_rvalid) begin
                check("ws0_latency", i - last0, 1);
                check("ws0_data", r0_rdata, (acc0.size() == 1) ? 32'h0 : 32'hA5A50001);
                check("ws0_err", r0_rerr, 0);
            end
            r0_valid = (i < 8);
            r0_write = (acc0.size() == 0);
            r0_addr = 0; r0_size = 2; r0_wdata = 32'hA5A50001;
            if (r0_valid && r0_ready) begin acc0.push_back(i); last0 = i; end
            @(negedge clk);
        end
        r0_valid = 0;
        check("ws0_nacc", acc0.size(), 4);
        for (int k = 1; k < acc0.size(); k++) check("ws0_gap", acc0[k] - acc0[k-1], 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
